// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the unified memory port arbiter.
//   arb_src_t   : owner tag of an in-flight memory access
//   MEM_LAT_MAX : largest supported memory read latency
//   WE_W        : byte-enable width of the data port
//   grant_src() : tag to record for the access granted this cycle
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_LAT_MAX = 4;
    localparam int unsigned WE_W        = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DM   = 2'd2
    } arb_src_t;

    // Only reads return data, so a DM write is tagged like an idle cycle.
    function automatic arb_src_t grant_src(input logic if_gnt,
                                           input logic dm_gnt,
                                           input logic dm_rd);
        if (dm_gnt) begin
            return dm_rd ? SRC_DM : SRC_NONE;
        end
        if (if_gnt) begin
            return SRC_IF;
        end
        return SRC_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_delay_line.sv
// tag_delay_line
// DEPTH-stage shift register of arb_src_t tags; the last stage names the
// owner of the memory read data arriving this cycle.
//   clk, rst_n : clock, asynchronous active-low clear of all stages
//   i_tag      : tag loaded into stage 0 every cycle
//   o_tag      : tag leaving the last stage
module tag_delay_line
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  arb_src_t i_tag,
    output arb_src_t o_tag
);

    arb_src_t r_stage [DEPTH];

    // Clearing on reset drops any responses still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= SRC_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF, read only) and data
// memory access (DM). One combinational grant per cycle; read owners are
// tracked in a MEM_LAT-deep tag line so each response returns to its issuer.
// Compile option ARB_RR_EN: round-robin arbitration instead of fixed DM
// priority.
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..MEM_LAT_MAX).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_if_req/i_if_addr               fetch request
//   o_if_gnt/o_if_rvalid/o_if_rdata  fetch grant and response
//   i_dm_req/i_dm_we/i_dm_addr/i_dm_wdata  data request (we==0 is a read)
//   o_dm_gnt/o_dm_rvalid/o_dm_rdata  data grant and response
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata/i_mem_rdata  memory macro port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic [WE_W-1:0]   i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_mem_en,
    output logic [WE_W-1:0]   o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    logic     w_if_gnt;
    logic     w_dm_gnt;
    arb_src_t w_tag_in;
    arb_src_t w_tag_last;

`ifdef ARB_RR_EN
    // High when IF should win the next conflict (i.e. DM won last).
    logic r_rr_if_next;

    // Round-robin grant; grants are held low while reset is asserted.
    always_comb begin
        w_if_gnt = 1'b0;
        w_dm_gnt = 1'b0;
        if (rst_n) begin
            if (i_if_req && i_dm_req) begin
                w_if_gnt = r_rr_if_next;
                w_dm_gnt = !r_rr_if_next;
            end else begin
                w_if_gnt = i_if_req;
                w_dm_gnt = i_dm_req;
            end
        end
    end

    // Records the most recent winner, contested or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_if_next <= 1'b1;
        end else if (w_dm_gnt) begin
            r_rr_if_next <= 1'b1;
        end else if (w_if_gnt) begin
            r_rr_if_next <= 1'b0;
        end
    end
`else
    // Fixed DM priority; grants are held low while reset is asserted.
    always_comb begin
        w_dm_gnt = rst_n && i_dm_req;
        w_if_gnt = rst_n && i_if_req && !i_dm_req;
    end
`endif

    assign o_if_gnt = w_if_gnt;
    assign o_dm_gnt = w_dm_gnt;
    assign o_mem_en = w_if_gnt || w_dm_gnt;

    // Memory port mux; idle cycles present an all-zero request.
    always_comb begin
        o_mem_we    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_dm_gnt) begin
            o_mem_we    = i_dm_we;
            o_mem_addr  = i_dm_addr;
            o_mem_wdata = i_dm_wdata;
        end else if (w_if_gnt) begin
            o_mem_addr  = i_if_addr;
        end
    end

    assign w_tag_in = grant_src(w_if_gnt, w_dm_gnt, i_dm_we == '0);

    tag_delay_line #(
        .DEPTH (MEM_LAT)
    ) u_tag_line (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_last)
    );

    // Read data is shared; consumers qualify it with their rvalid.
    assign o_if_rvalid = (w_tag_last == SRC_IF);
    assign o_dm_rvalid = (w_tag_last == SRC_DM);
    assign o_if_rdata  = i_mem_rdata;
    assign o_dm_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances with MEM_LAT = 1, 2, 3 share
// one stimulus stream. Each has its own memory macro stub; a transaction
// level model (memory array + per-lane response queues) predicts outputs.
module tb_mem_port_arbiter;

    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic        if_gnt    [NL];
    logic        if_rvalid [NL];
    logic [31:0] if_rdata  [NL];
    logic        dm_gnt    [NL];
    logic        dm_rvalid [NL];
    logic [31:0] dm_rdata  [NL];
    logic        mem_en    [NL];
    logic [3:0]  mem_we    [NL];
    logic [31:0] mem_addr  [NL];
    logic [31:0] mem_wdata [NL];
    logic [31:0] mem_rdata [NL];

    logic [31:0] smem  [NL][256];
    logic [31:0] spipe [NL][4];
    bit          stub_init = 1'b0;

    function automatic int lat_of(int l);
        return l + 1;
    endfunction

    function automatic logic [31:0] init_word(int i);
        if (i == 64) return 32'h0000_0013;
        if (i == 1)  return 32'h1122_3344;
        return {8'(i), 8'(~i), 8'h5A, 8'(i ^ 'h3C)};
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        mem_port_arbiter #(
            .ADDR_W  (32),
            .DATA_W  (32),
            .MEM_LAT (g + 1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_if_req    (if_req),
            .i_if_addr   (if_addr),
            .o_if_gnt    (if_gnt[g]),
            .o_if_rvalid (if_rvalid[g]),
            .o_if_rdata  (if_rdata[g]),
            .i_dm_req    (dm_req),
            .i_dm_we     (dm_we),
            .i_dm_addr   (dm_addr),
            .i_dm_wdata  (dm_wdata),
            .o_dm_gnt    (dm_gnt[g]),
            .o_dm_rvalid (dm_rvalid[g]),
            .o_dm_rdata  (dm_rdata[g]),
            .o_mem_en    (mem_en[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .i_mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = spipe[g][g];
    end

    // Memory macro stub: read data appears lat cycles after the access edge.
    always @(posedge clk) begin
        if (!stub_init) begin
            for (int l = 0; l < NL; l++)
                for (int i = 0; i < 256; i++) smem[l][i] <= init_word(i);
            stub_init <= 1'b1;
        end else begin
            for (int l = 0; l < NL; l++) begin
                for (int k = 1; k < 4; k++) spipe[l][k] <= spipe[l][k-1];
                spipe[l][0] <= (mem_en[l] && mem_we[l] == 4'b0) ?
                               smem[l][mem_addr[l][9:2]] : 32'hDEAD_BEEF;
                for (int b = 0; b < 4; b++)
                    if (mem_en[l] && mem_we[l][b])
                        smem[l][mem_addr[l][9:2]][8*b +: 8] <= mem_wdata[l][8*b +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          is_dm;
        logic [31:0] data;
    } resp_t;

    resp_t       rq [NL][$];
    logic [31:0] rmem [256];
    bit          favor_if;
    int          cyc;
    bit          g_if, g_dm;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d cyc%0d: got %h want %h", name, lane, cyc, act, exp);
        end
    endtask

    // Compare every output of every lane against the model.
    task automatic sample();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_we;
        bit          have;
        resp_t       h;
        @(negedge clk);
        g_if = 1'b0;
        g_dm = 1'b0;
        if (rst_n) begin
`ifdef ARB_RR_EN
            if (if_req && dm_req) begin
                g_if = favor_if;
                g_dm = !favor_if;
            end else begin
                g_if = if_req;
                g_dm = dm_req;
            end
`else
            g_dm = dm_req;
            g_if = if_req && !dm_req;
`endif
        end
        e_addr  = g_dm ? dm_addr : (g_if ? if_addr : 32'h0);
        e_wdata = g_dm ? dm_wdata : 32'h0;
        e_we    = g_dm ? dm_we : 4'h0;
        for (int l = 0; l < NL; l++) begin
            chk("if_gnt",    l, 32'(if_gnt[l]), 32'(g_if));
            chk("dm_gnt",    l, 32'(dm_gnt[l]), 32'(g_dm));
            chk("mem_en",    l, 32'(mem_en[l]), 32'(g_if | g_dm));
            chk("mem_we",    l, 32'(mem_we[l]), 32'(e_we));
            chk("mem_addr",  l, mem_addr[l], e_addr);
            chk("mem_wdata", l, mem_wdata[l], e_wdata);
            have = (rq[l].size() > 0) && (rq[l][0].due == cyc);
            h    = have ? rq[l][0] : '{0, 1'b0, 32'h0};
            chk("if_rvalid", l, 32'(if_rvalid[l]), 32'(have && !h.is_dm));
            chk("dm_rvalid", l, 32'(dm_rvalid[l]), 32'(have && h.is_dm));
            if (have) begin
                if (h.is_dm) chk("dm_rdata", l, dm_rdata[l], h.data);
                else         chk("if_rdata", l, if_rdata[l], h.data);
                void'(rq[l].pop_front());
            end
        end
    endtask

    task automatic push_rd(input bit is_dm, input logic [31:0] addr);
        resp_t r;
        for (int l = 0; l < NL; l++) begin
            r.due   = cyc + lat_of(l) - 1;
            r.is_dm = is_dm;
            r.data  = rmem[addr[9:2]];
            rq[l].push_back(r);
        end
    endtask

    // Clock edge: the model consumes whatever was granted.
    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            if (g_dm) begin
                if (dm_we != 4'b0) begin
                    for (int b = 0; b < 4; b++)
                        if (dm_we[b]) rmem[dm_addr[9:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                end else begin
                    push_rd(1'b1, dm_addr);
                end
            end
            if (g_if) push_rd(1'b0, if_addr);
            if (g_dm)      favor_if = 1'b1;
            else if (g_if) favor_if = 1'b0;
        end
    endtask

    task automatic rst_assert();
        rst_n    = 1'b0;
        favor_if = 1'b1;
        for (int l = 0; l < NL; l++) rq[l].delete();
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (n) begin
            sample();
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = init_word(i);
        cyc      = 0;
        if_req   = 1'b1;
        if_addr  = 32'h100;
        dm_req   = 1'b0;
        dm_we    = 4'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        rst_assert();

        // Reset: requests are ignored while rst_n is low.
        repeat (2) begin
            sample();
            chk("rst_if_gnt", 0, 32'(if_gnt[0]), 32'h0);
            chk("rst_mem_en", 0, 32'(mem_en[0]), 32'h0);
            advance();
        end
        rst_n = 1'b1;

        // Single fetch at 0x100.
        sample();
        chk("t1_if_gnt", 0, 32'(if_gnt[0]), 32'h1);
        advance();
        if_req = 1'b0;
        sample();
        chk("t1_if_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
        chk("t1_if_rdata",  0, if_rdata[0], 32'h0000_0013);
        advance();
        idle(3);

        // Conflict: DM read wins, IF follows next cycle.
        dm_req = 1'b1; dm_we = 4'b0; dm_addr = 32'h2000;
        if_req = 1'b1; if_addr = 32'h104;
        sample();
        chk("t2_dm_gnt", 0, 32'(dm_gnt[0]), 32'h1);
        chk("t2_if_gnt", 0, 32'(if_gnt[0]), 32'h0);
        advance();
        dm_req = 1'b0;
        sample();
        chk("t2_if_gnt2",   0, 32'(if_gnt[0]), 32'h1);
        chk("t2_dm_rvalid", 0, 32'(dm_rvalid[0]), 32'h1);
        advance();
        if_req = 1'b0;
        sample();
        chk("t2_if_rvalid", 0, 32'(if_rvalid[0]), 32'h1);
        advance();
        idle(3);

        // Partial write then read-back.
        dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 32'h2004; dm_wdata = 32'hAABB_CCDD;
        sample();
        chk("t3_mem_we", 0, 32'(mem_we[0]), 32'h3);
        advance();
        dm_we = 4'b0;
        idle(4);
        dm_req = 1'b1; dm_addr = 32'h2004;
        sample();
        advance();
        dm_req = 1'b0;
        sample();
        chk("t3_dm_rvalid", 0, 32'(dm_rvalid[0]), 32'h1);
        chk("t3_dm_rdata",  0, dm_rdata[0], 32'h1122_CCDD);
        advance();
        idle(4);

        // Three back-to-back fetches, checked on the MEM_LAT=3 lane.
        for (int k = 0; k < 3; k++) begin
            if_req  = 1'b1;
            if_addr = 32'h200 + 32'(4 * k);
            sample();
            advance();
        end
        if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("t4_if_rvalid", 2, 32'(if_rvalid[2]), 32'h1);
            chk("t4_if_rdata",  2, if_rdata[2], init_word(128 + k));
            advance();
        end
        idle(4);

        // Both requesters held for 6 cycles after a reset.
        rst_assert();
        sample();
        advance();
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h040;
        dm_req = 1'b1; dm_we = 4'b0; dm_addr = 32'h080;
        for (int k = 0; k < 6; k++) begin
            sample();
`ifdef ARB_RR_EN
            chk("t5_if_gnt", 0, 32'(if_gnt[0]), 32'(k % 2 == 0));
            chk("t5_dm_gnt", 0, 32'(dm_gnt[0]), 32'(k % 2 != 0));
`else
            chk("t5_if_gnt", 0, 32'(if_gnt[0]), 32'h0);
            chk("t5_dm_gnt", 0, 32'(dm_gnt[0]), 32'h1);
`endif
            advance();
        end
        idle(4);

        // Reset one cycle after a grant drops the response (MEM_LAT=2 lane).
        if_req = 1'b1; if_addr = 32'h300;
        sample();
        advance();
        if_req = 1'b0;
        rst_assert();
        sample();
        chk("t6_rst_rvalid", 1, 32'(if_rvalid[1]), 32'h0);
        advance();
        rst_n = 1'b1;
        sample();
        chk("t6_post_rvalid", 1, 32'(if_rvalid[1]), 32'h0);
        advance();
        if_req = 1'b1; if_addr = 32'h304;
        sample();
        advance();
        if_req = 1'b0;
        sample();
        advance();
        sample();
        chk("t6_new_rvalid", 1, 32'(if_rvalid[1]), 32'h1);
        chk("t6_new_rdata",  1, if_rdata[1], init_word(193));
        advance();
        idle(4);

        // Randomized traffic with one reset pulse in the middle.
        for (int i = 0; i < 600; i++) begin
            sample();
            advance();
            if (i == 300) rst_assert();
            if (i == 302) rst_n = 1'b1;
            if (g_if && rst_n) if_req = 1'b0;
            if (g_dm && rst_n) dm_req = 1'b0;
            if (!if_req) begin
                if_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                if ($urandom_range(0, 1) == 1) if_req = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                if_req = 1'b0;
            end
            if (!dm_req) begin
                dm_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
                dm_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
                dm_wdata = $urandom;
                if ($urandom_range(0, 2) != 0) dm_req = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                dm_req = 1'b0;
            end
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
